// File: rtl/uart_send_responder_if.sv
// Byte-send request channel between the CPU-side I/O unit (master) and the UART transmitter (slave).
// Only content[7:0] is meaningful; busy high means the request in this cycle is dropped.
interface uart_send_responder_if;
  logic        en;
  logic [31:0] content;
  logic        busy;

  modport master (output en, output content, input busy);
  modport slave  (input en, input content, output busy);
endinterface

// File: rtl/uart_send_responder.sv
// 8N1 UART transmitter behind a request channel; start bit 2 edges after accept, or 1 edge without SEND_FIFO_EN.
// busy (registers only) drops requests: FIFO full with SEND_FIFO_EN, otherwise any time a frame is in flight.
module uart_send_responder #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  uart_send_responder_if.slave req,
  output logic                 txd
);
  localparam int            BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] baud, baud_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          txd_nxt;
  logic          busy;
  logic          accept;
  logic          avail;
  logic          pop;
  logic [7:0]    next_byte;
  logic [31:0]   unused_bits;

  assign accept   = req.en && !busy;
  assign req.busy = busy;

`ifdef SEND_FIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;

  assign busy        = (count == (PW+1)'(FIFO_DEPTH));
  assign avail       = (count != '0);
  assign next_byte   = mem[rd_ptr];
  assign unused_bits = {req.content[31:8], 8'h00};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= req.content[7:0];
  end
`else
  // Without a FIFO the request feeds the shifter directly and busy covers the whole frame.
  assign busy        = (state != IDLE);
  assign avail       = accept;
  assign next_byte   = req.content[7:0];
  assign unused_bits = {req.content[31:8], 7'(FIFO_DEPTH), pop};
`endif

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    pop       = 1'b0;
    txd_nxt   = 1'b1;

    if (state != IDLE) baud_nxt = (baud == BAUD_LAST) ? '0 : baud + 1'b1;

    case (state)
      IDLE: begin
        baud_nxt = '0;
        idx_nxt  = '0;
        if (avail) begin
          pop       = 1'b1;
          shreg_nxt = next_byte;
          state_nxt = START;
        end
      end
      START: begin
        if (baud == BAUD_LAST) begin
          state_nxt = DATA;
          idx_nxt   = '0;
        end
      end
      DATA: begin
        if (baud == BAUD_LAST) begin
          if (idx == 3'd7) state_nxt = STOP;
          else             idx_nxt   = idx + 1'b1;
        end
      end
      STOP: begin
        // Chaining straight into START keeps consecutive frames gap-free.
        if (baud == BAUD_LAST) begin
          if (avail) begin
            pop       = 1'b1;
            shreg_nxt = next_byte;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    case (state_nxt)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = shreg_nxt[idx_nxt];
      default: txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      baud  <= '0;
      idx   <= '0;
      shreg <= '0;
      txd   <= 1'b1;
    end else begin
      state <= state_nxt;
      baud  <= baud_nxt;
      idx   <= idx_nxt;
      shreg <= shreg_nxt;
      txd   <= txd_nxt;
    end
  end
endmodule

// File: tb/tb_uart_send_responder.sv
// Bench for uart_send_responder: UART monitor checks each frame against a scoreboard of expected bytes and start cycles.
module tb_uart_send_responder;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
`ifdef SEND_FIFO_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic txd;

  uart_send_responder_if req_if();

  uart_send_responder #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .req  (req_if.slave),
    .txd  (txd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  typedef struct {
    logic [31:0] content;
    logic [7:0]  exp;
  } vec_t;

  exp_t        sb[$];
  int          checks      = 0;
  int          failures    = 0;
  int          frames_seen = 0;
  int          frames_exp  = 0;
  int          mon_cnt     = 0;
  int          mon_start   = 0;
  logic [39:0] frm;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_frame();
    logic       ok;
    logic [9:0] bits;
    exp_t       e;
    ok = 1'b1;
    for (int b = 0; b < 10; b++) begin
      bits[b] = frm[b*CPB];
      for (int s = 1; s < CPB; s++)
        if (frm[b*CPB+s] !== bits[b]) ok = 1'b0;
    end
    if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
    frames_seen++;
    check("frame_shape", 32'(ok), 32'd1);
    check("frame_expected", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("frame_data", 32'(bits[8:1]), 32'(e.data));
      check("frame_start_cycle", mon_start, e.start);
    end
  endtask

  // Sample-by-sample receiver; a reset abandons any frame in progress.
  always @(negedge clk) begin
    if (!rstn) begin
      mon_cnt = 0;
    end else if (mon_cnt == 0) begin
      if (txd == 1'b0) begin
        frm[0]    = 1'b0;
        mon_start = cyc;
        mon_cnt   = 1;
      end
    end else begin
      frm[mon_cnt] = txd;
      mon_cnt++;
      if (mon_cnt == FRAME) begin
        mon_cnt = 0;
        check_frame();
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) step();
  endtask

  task automatic expect_byte(input logic [7:0] d, input int start);
    exp_t x;
    x.data  = d;
    x.start = start;
    sb.push_back(x);
    frames_exp++;
  endtask

  // Drives a one-cycle request; the accepting edge is the next posedge (cyc+1).
  task automatic send_one(input logic [31:0] c, input logic [7:0] e);
    req_if.en      = 1'b1;
    req_if.content = c;
    expect_byte(e, cyc + 1 + LAT);
    step();
    req_if.en      = 1'b0;
    req_if.content = 32'h0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_cnt != 0 || req_if.busy) && n < budget) begin
      step();
      n++;
    end
    check("drain_within_budget", 32'(n < budget), 32'd1);
    step();
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   c0;
    logic busy_seen;

    vecs[0] = '{32'hDEAD_BE55, 8'h55};
    vecs[1] = '{32'hFFFF_FF00, 8'h00};
    vecs[2] = '{32'h0000_00A3, 8'hA3};
    vecs[3] = '{32'h1234_5681, 8'h81};
    vecs[4] = '{32'h7F7F_7FFF, 8'hFF};

    req_if.en      = 1'b0;
    req_if.content = 32'h0;
    rstn           = 1'b0;
    repeat (3) step();
    check("reset_txd", 32'(txd), 32'd1);
    check("reset_busy", 32'(req_if.busy), 32'd0);
    rstn = 1'b1;
    step();
    check("idle_txd", 32'(txd), 32'd1);

    for (int i = 0; i < 5; i++) begin
      send_one(vecs[i].content, vecs[i].exp);
      wait_idle(200);
    end

`ifdef SEND_FIFO_EN
    // Three consecutive accepts must produce gap-free frames without busy.
    c0             = cyc;
    busy_seen      = 1'b0;
    req_if.en      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_if.content = 32'(i + 1);
      expect_byte(8'(i + 1), c0 + 1 + LAT + FRAME * i);
      busy_seen |= req_if.busy;
      step();
    end
    req_if.en = 1'b0;
    for (int i = 0; i < 125; i++) begin
      busy_seen |= req_if.busy;
      step();
    end
    check("b2b_busy_never", 32'(busy_seen), 32'd0);
    wait_idle(300);

    // Six pushes into a depth-4 FIFO while the first frame drains: the sixth is dropped.
    c0        = cyc;
    req_if.en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_if.content = 32'hABCD_00A0 + 32'(i);
      if (i < 5) expect_byte(8'hA0 + 8'(i), c0 + 1 + LAT + FRAME * i);
      if (i == 4) check("full_busy_before", 32'(req_if.busy), 32'd0);
      if (i == 5) check("full_busy_after", 32'(req_if.busy), 32'd1);
      step();
    end
    req_if.en      = 1'b0;
    req_if.content = 32'h0;
    wait_cyc(c0 + 1 + LAT + FRAME - 1);
    check("full_busy_until_pop", 32'(req_if.busy), 32'd1);
    step();
    check("full_busy_falls", 32'(req_if.busy), 32'd0);
    wait_idle(400);
`else
    // A request 10 cycles into a frame is ignored; busy spans exactly one frame.
    c0 = cyc;
    send_one(32'h0000_0011, 8'h11);
    wait_cyc(c0 + 1 + 10);
    check("drop_busy_high", 32'(req_if.busy), 32'd1);
    req_if.en      = 1'b1;
    req_if.content = 32'h0000_0077;
    step();
    req_if.en      = 1'b0;
    req_if.content = 32'h0;
    wait_cyc(c0 + 1 + FRAME - 1);
    check("drop_busy_last", 32'(req_if.busy), 32'd1);
    step();
    check("drop_busy_falls", 32'(req_if.busy), 32'd0);
    wait_idle(200);
    repeat (FRAME + 10) step();
`endif

    // Reset during data bit 3 of 8'hA5 (bit 3 is 0, so txd must jump to 1).
    c0 = cyc;
    send_one(32'h0000_00A5, 8'hA5);
    wait_cyc(c0 + 1 + LAT + CPB + 3 * CPB + 1);
    check("pre_reset_bit3", 32'(txd), 32'd0);
    #2 rstn = 1'b0;
    #1;
    check("async_reset_txd", 32'(txd), 32'd1);
    check("async_reset_busy", 32'(req_if.busy), 32'd0);
    frames_exp -= sb.size();
    sb.delete();
    repeat (3) step();
    rstn = 1'b1;
    step();
    check("post_reset_txd", 32'(txd), 32'd1);
    check("post_reset_busy", 32'(req_if.busy), 32'd0);
    send_one(32'h0000_005A, 8'h5A);
    wait_idle(200);

    repeat (FRAME) step();
    check("frames_total", frames_seen, frames_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
